// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD / SZ_RSVD)
//   - FSM state encoding
//   - request legality helpers (misalignment, word index range)
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_MERGE   = 3'd3,
        ST_WRITE   = 3'd4,
        ST_RESP    = 3'd5
    } lsu_state_t;

    // Byte accesses are always aligned; halves need an even address,
    // words need a multiple of four.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
        logic mis;
        case (size)
            SZ_HALF: mis = offset[0];
            SZ_WORD: mis = (offset != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic is_out_of_range(input logic [29:0] word_idx,
                                             input int unsigned depth);
        return ({2'b00, word_idx} >= depth);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Combinational lane handling for the load/store unit.
//   extract: picks the addressed byte/half out of a memory word and sign- or
//            zero-extends it to 32 bits (word accesses pass straight through).
//   merge:   overlays the low bits of the store data onto the addressed lane of
//            the old memory word, leaving the other lanes untouched.
// Ports:
//   rd_word     in  32  word read from memory (load source / RMW old word)
//   wr_data     in  32  right-aligned store data
//   offset      in  2   byte offset within the word (addr[1:0])
//   size        in  2   access size encoding
//   is_unsigned in  1   zero-extend loads when set
//   load_data   out 32  extended load value
//   store_word  out 32  merged word to write back
// -----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] wr_data,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        byte_sign;
    logic        half_sign;

    // Little-endian lanes: byte k lives at [8k+7:8k], half lane picked by addr[1].
    always_comb begin
        byte_lane = rd_word[{offset, 3'b000} +: 8];
        half_lane = rd_word[{offset[1], 4'b0000} +: 16];
        byte_sign = byte_lane[7] & ~is_unsigned;
        half_sign = half_lane[15] & ~is_unsigned;
    end

    always_comb begin
        load_data = rd_word;
        case (size)
            SZ_BYTE: load_data = {{24{byte_sign}}, byte_lane};
            SZ_HALF: load_data = {{16{half_sign}}, half_lane};
            default: load_data = rd_word;
        endcase
    end

    always_comb begin
        store_word = rd_word;
        case (size)
            SZ_BYTE: store_word[{offset, 3'b000} +: 8]        = wr_data[7:0];
            SZ_HALF: store_word[{offset[1], 4'b0000} +: 16]   = wr_data[15:0];
            SZ_WORD: store_word                               = wr_data;
            default: store_word                               = rd_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Initiator-side access controller for a word-addressed single-port data
// memory. Turns byte/half/word load and store requests into mem_rd/mem_wr word
// transactions; sub-word stores use read-modify-write. Illegal requests
// (reserved size, misaligned, word index >= DEPTH) complete with rsp_err and
// never strobe the memory.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_we, req_size,
//   req_unsigned, req_addr,
//   req_wdata                   request fields, registered at acceptance
//   rsp_valid                   one-cycle completion pulse
//   rsp_rdata                   load result (0 for stores and errors)
//   rsp_err                     request rejected
//   mem_address                 word index (req_addr >> 2)
//   mem_write_data              full word to write
//   mem_rd, mem_wr              memory strobes, one cycle each
//   mem_read_data               memory output, valid the cycle after mem_rd
//
// State    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | waiting for a request, req_ready high
// READ     | mem_rd high; word index presented to memory
// CAPTURE  | read data valid; extract/extend lane into rsp_rdata
// MERGE    | read data valid; overlay store lane into mem_write_data
// WRITE    | mem_wr high with the full word
// RESP     | rsp_valid high for one cycle
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [31:0] mem_read_data
);

    lsu_state_t  state_q, state_d;

    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;

    logic        rd_d, wr_d, rsp_valid_d, rsp_err_d;
    logic [31:0] rsp_rdata_d, addr_d, wdata_d;

    logic        req_bad;
    logic        accept;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid & req_ready;

    assign req_bad = (req_size == SZ_RSVD)
                   | is_misaligned(req_size, req_addr[1:0])
                   | is_out_of_range(req_addr[31:2], DEPTH);

    lsu_align u_align (
        .rd_word     (mem_read_data),
        .wr_data     (wdata_q),
        .offset      (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .load_data   (load_data),
        .store_word  (merged_word)
    );

    // Next state and next values of every registered output. Strobes and
    // rsp_valid are computed for the state being entered, so each is high
    // exactly during that state.
    always_comb begin
        state_d     = state_q;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;
        addr_d      = mem_address;
        wdata_d     = mem_write_data;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_bad) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        addr_d = {2'b00, req_addr[31:2]};
                        if (req_we && (req_size == SZ_WORD)) begin
                            state_d = ST_WRITE;
                            wr_d    = 1'b1;
                            wdata_d = req_wdata;
                        end else begin
                            state_d = ST_READ;
                            rd_d    = 1'b1;
                        end
                    end
                end
            end
            ST_READ: begin
                state_d = we_q ? ST_MERGE : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = load_data;
            end
            ST_MERGE: begin
                state_d = ST_WRITE;
                wr_d    = 1'b1;
                wdata_d = merged_word;
            end
            ST_WRITE: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            mem_rd         <= 1'b0;
            mem_wr         <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_err        <= 1'b0;
            rsp_rdata      <= 32'h0;
            mem_address    <= 32'h0;
            mem_write_data <= 32'h0;
        end else begin
            state_q        <= state_d;
            mem_rd         <= rd_d;
            mem_wr         <= wr_d;
            rsp_valid      <= rsp_valid_d;
            rsp_err        <= rsp_err_d;
            rsp_rdata      <= rsp_rdata_d;
            mem_address    <= addr_d;
            mem_write_data <= wdata_d;
        end
    end

    // Request fields are only needed after acceptance, so they hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            wdata_q <= 32'h0;
        end else if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            off_q   <= req_addr[1:0];
            wdata_q <= req_wdata;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_read_data = 32'h0;

    load_store_unit #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory behind the unit, plus the reference copy the model reasons about.
    logic [31:0] mem     [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];

    always @(posedge clk) begin
        if (mem_rd) mem_read_data <= mem[mem_address[7:0]];
        if (mem_wr) mem[mem_address[7:0]] = mem_write_data;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          delay;
        int          n_rd;
        int          n_wr;
        int          acc_edge;
        logic        is_store;
        logic [31:0] widx;
        logic [31:0] new_word;
    } exp_t;

    exp_t exp_q[$];

    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic exp_t model(input logic we, input logic [1:0] sz, input logic uns,
                                   input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int nb, sh;
        logic [63:0] mask, v, w;
        e.rdata = 0; e.err = 0; e.delay = 0; e.n_rd = 0; e.n_wr = 0;
        e.acc_edge = 0; e.is_store = we; e.widx = 0; e.new_word = 0;
        if (sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) ||
            (a / 4) >= DEPTH) begin
            e.err = 1;
            return e;
        end
        e.widx = a / 4;
        nb   = size_bytes(sz);
        sh   = 8 * int'(a % 4);
        mask = (64'd1 << (8 * nb)) - 64'd1;
        w    = {32'h0, ref_mem[e.widx]};
        if (!we) begin
            v = (w >> sh) & mask;
            if (!uns && nb < 4 && ((v >> (8 * nb - 1)) & 64'd1) != 0) v = v | ~mask;
            e.rdata = v[31:0];
            e.delay = 2; e.n_rd = 1;
        end else begin
            v = (w & ~(mask << sh)) | (({32'h0, wd} & mask) << sh);
            e.new_word = v[31:0];
            if (nb == 4) begin e.delay = 1; e.n_wr = 1; end
            else         begin e.delay = 3; e.n_rd = 1; e.n_wr = 1; end
        end
        return e;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    int rd_cnt = 0, wr_cnt = 0;
    int last_rsp_edge = 0;
    bit held = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd && mem_wr) fail_now("strobe_overlap");
            if (mem_rd || mem_wr) begin
                if (exp_q.size() == 0) fail_now("strobe_without_request");
                else begin
                    chk("mem_address", mem_address, exp_q[0].widx);
                    if (mem_wr) chk("mem_write_data", mem_write_data, exp_q[0].new_word);
                end
            end
            if (mem_rd) rd_cnt++;
            if (mem_wr) wr_cnt++;

            if (rsp_valid) begin
                if (exp_q.size() == 0) fail_now("unexpected_rsp");
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                    chk("rsp_delay", 32'(cyc - e.acc_edge), 32'(e.delay));
                    chk("rd_strobes", 32'(rd_cnt), 32'(e.n_rd));
                    chk("wr_strobes", 32'(wr_cnt), 32'(e.n_wr));
                    if (e.is_store && !e.err) ref_mem[e.widx] = e.new_word;
                end
                rd_cnt = 0;
                wr_cnt = 0;
                last_rsp_edge = cyc;
                held = req_valid;
            end

            if (req_valid && req_ready) begin
                exp_t e;
                e = model(req_we, req_size, req_unsigned, req_addr, req_wdata);
                e.acc_edge = cyc + 1;
                if (held) chk("b2b_spacing", 32'(e.acc_edge - last_rsp_edge), 32'd2);
                held = 0;
                exp_q.push_back(e);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input bit hold);
        int waited = 0;
        bit acc = 0;
        req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        while (!acc && waited < 20) begin
            @(negedge clk);
            if (req_ready) acc = 1;
            else waited++;
        end
        if (!acc) fail_now("accept_timeout");
        @(posedge clk); #1;
        if (!hold || !acc) req_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) fail_now("drain_timeout");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout (t=%0t)", $time);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
        ref_mem[8]  = 32'h80FF7F01;
        ref_mem[12] = 32'h01020304;
        for (int i = 0; i < DEPTH; i++) mem[i] = ref_mem[i];

        // reset values
        #12;
        chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("rst_mem_rd", {31'h0, mem_rd}, 32'd0);
        chk("rst_mem_wr", {31'h0, mem_wr}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_write_data", mem_write_data, 32'd0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        // word store then load
        issue(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0);
        issue(0, 2'd2, 0, 32'h10, 32'h0, 0);
        drain();
        chk("word_store_mem", mem[4], 32'hDEADBEEF);

        // byte loads of 0x80FF7F01
        issue(0, 2'd0, 0, 32'h23, 32'h0, 0);
        issue(0, 2'd0, 1, 32'h23, 32'h0, 0);
        issue(0, 2'd0, 0, 32'h20, 32'h0, 0);
        issue(0, 2'd1, 0, 32'h22, 32'h0, 0);

        // sub-word stores with read-modify-write
        issue(1, 2'd2, 0, 32'h20, 32'h11223344, 0);
        issue(1, 2'd0, 0, 32'h21, 32'hFFFFFFAB, 0);
        issue(1, 2'd1, 0, 32'h22, 32'h1234CAFE, 0);
        issue(0, 2'd2, 0, 32'h20, 32'h0, 0);
        drain();
        chk("rmw_result", mem[8], 32'hCAFEAB44);

        // rejected requests
        issue(0, 2'd1, 0, 32'h01, 32'h0, 0);
        issue(1, 2'd2, 0, 32'h06, 32'h55555555, 0);
        issue(0, 2'd3, 0, 32'h00, 32'h0, 0);
        issue(1, 2'd2, 0, 32'(4 * DEPTH), 32'h77777777, 0);
        issue(0, 2'd2, 0, 32'(4 * DEPTH - 4), 32'h0, 0);
        drain();

        // back-to-back with req_valid held
        issue(0, 2'd2, 0, 32'h10, 32'h0, 1);
        issue(1, 2'd2, 0, 32'h14, 32'h0BADF00D, 1);
        issue(1, 2'd0, 0, 32'h17, 32'h000000E7, 1);
        issue(0, 2'd1, 1, 32'h16, 32'h0, 1);
        issue(0, 2'd1, 0, 32'h03, 32'h0, 0);
        drain();

        // reset while in MERGE abandons the RMW
        issue(1, 2'd0, 0, 32'h31, 32'h5A, 0);
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        chk("midrst_mem_rd", {31'h0, mem_rd}, 32'd0);
        chk("midrst_mem_wr", {31'h0, mem_wr}, 32'd0);
        chk("midrst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("midrst_req_ready", {31'h0, req_ready}, 32'd1);
        chk("midrst_mem_write_data", mem_write_data, 32'd0);
        exp_q.delete();
        rd_cnt = 0; wr_cnt = 0; held = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_req_ready", {31'h0, req_ready}, 32'd1);
        chk("abandoned_word", mem[12], 32'h01020304);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [1:0] sz;
            logic [1:0] off;
            int widx;
            bit hold;
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            widx = ($urandom_range(0, 9) == 0) ? 254 + int'($urandom_range(0, 3))
                                               : int'($urandom_range(0, 15));
            off = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) off[0] = 1'b0;
                else if (sz == 2'd2) off = 2'd0;
            end
            hold = (n < 299) && ($urandom_range(0, 2) == 0);
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                  32'(widx * 4) + 32'(off), $urandom, hold);
            if (!hold) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
        req_valid = 0;
        drain();

        for (int i = 0; i < DEPTH; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
